// File: rtl/alu_sequencer_if.sv
// Request/response bus between a client and the ALU sequencer.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request and the response side.
interface alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_err;

  // Client side: issues requests, consumes responses.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences AND/OR/ADD/SUB/MUL requests through an external combinational ALU.
// Latency: accept edge to rsp_valid is 1 edge (AND/OR/ADD/illegal), 2 (SUB), WIDTH (MUL).
// Backpressure: one request in flight; the response is held until rsp_ready, req_ready only in IDLE.
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_z
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_NEG,
    S_SUBADD,
    S_MUL,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_err;

  logic             w_illegal;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_mul_last;

  // Ops 101..111 never touch the ALU.
  assign w_illegal  = (r_op > 3'd4);
  // Shift-and-add: only add the shifted multiplicand when the current multiplier bit is set.
  assign w_acc_nxt  = r_mplier[0] ? alu_out : r_acc;
  assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

  // req_ready is gated by rst_n so it reads 0 for the whole reset, not just after the first edge.
  assign bus.req_ready  = (r_state == S_IDLE) && rst_n;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_carry  = r_carry;
  assign bus.rsp_zero   = r_zero;
  assign bus.rsp_err    = r_err;

  // ALU operand/select decode from the registered state; parked at zero when the ALU is idle.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = 4'b0000;
    case (r_state)
      S_EXEC: begin
        if (!w_illegal) begin
          alu_a   = r_a;
          alu_b   = r_b;
          alu_sel = {1'b0, r_op};
        end
      end
      S_NEG: begin
        alu_a   = ~r_b;
        alu_b   = WIDTH'(1);
        alu_sel = 4'b0010;
      end
      S_SUBADD: begin
        alu_a   = r_a;
        alu_b   = r_t;
        alu_sel = 4'b0010;
      end
      S_MUL: begin
        alu_a   = r_acc;
        alu_b   = r_mcand;
        alu_sel = 4'b0010;
      end
      default: begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = 4'b0000;
      end
    endcase
  end

  // Sequencer FSM with registered response outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_t         <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op <= bus.req_op;
            r_a  <= bus.req_a;
            r_b  <= bus.req_b;
            case (bus.req_op)
              3'd3: r_state <= S_NEG;
              3'd4: begin
                r_acc    <= '0;
                r_mcand  <= bus.req_a;
                r_mplier <= bus.req_b;
                r_cnt    <= '0;
                r_state  <= S_MUL;
              end
              default: r_state <= S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          if (w_illegal) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
            r_err    <= 1'b1;
          end else begin
            r_result <= alu_out;
            r_carry  <= (r_op == 3'd2) ? alu_cout : 1'b0;
            r_zero   <= alu_z;
            r_err    <= 1'b0;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_NEG: begin
          // Two's-complement of B; the carry out of this step is meaningless.
          r_t     <= alu_out;
          r_state <= S_SUBADD;
        end
        S_SUBADD: begin
          r_result    <= alu_out;
          r_carry     <= alu_cout;
          r_zero      <= alu_z;
          r_err       <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_mul_last) begin
            r_result    <= w_acc_nxt;
            r_carry     <= 1'b0;
            r_zero      <= (w_acc_nxt == '0);
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: random and directed requests against an arithmetic reference model.
// Expected responses queue up at issue time; an independent monitor pops and compares them.
// Response backpressure is randomised per response, or pinned to a fixed hold count.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_cout;
  logic        alu_z;

  alu_sequencer_if #(.WIDTH(32)) bus ();

  alu_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_cout (alu_cout),
    .alu_z    (alu_z)
  );

  typedef struct {
    logic [31:0] res;
    logic        carry;
    logic        zero;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   hold_cfg = -1;
  logic mon_active = 1'b0;

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External combinational ALU
  always_comb begin
    logic [32:0] s;
    s = 33'd0;
    case (alu_sel)
      4'b0000: s = {1'b0, alu_a & alu_b};
      4'b0001: s = {1'b0, alu_a | alu_b};
      4'b0010: s = {1'b0, alu_a} + {1'b0, alu_b};
      default: s = 33'd0;
    endcase
    alu_out  = s[31:0];
    alu_cout = s[32];
    alu_z    = (s[31:0] == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_note(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference model: what the operation means arithmetically, modulo 2^32.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    logic [31:0] nb;
    e.res = 32'd0; e.carry = 1'b0; e.err = 1'b0; e.lat = 1; e.acc_cyc = 0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin s = {1'b0, a} + {1'b0, b}; e.res = s[31:0]; e.carry = s[32]; end
      3'd3: begin
        nb = 32'd0 - b;
        s = {1'b0, a} + {1'b0, nb};
        e.res = s[31:0]; e.carry = s[32]; e.lat = 2;
      end
      3'd4: begin e.res = a * b; e.lat = 32; end
      default: begin e.res = 32'd0; e.err = 1'b1; end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 15));
      2: case ($urandom_range(0, 3))
           0: v = 32'h0000_0000;
           1: v = 32'hFFFF_FFFF;
           2: v = 32'h8000_0000;
           default: v = 32'h0000_0001;
         endcase
      default: v = 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
    endcase
    return v;
  endfunction

  // Raise req_valid, wait for req_ready; the following rising edge accepts.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    t = 0;
    while (bus.req_ready !== 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        fail_note("req_ready_wait");
        bus.req_valid = 1'b0;
        return;
      end
    end
    e = model(op, a, b);
    e.acc_cyc = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || mon_active || bus.rsp_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_note("drain");
  endtask

  // Response consumer: hold rsp_ready low for 'hold' valid cycles, then accept.
  initial begin
    int vcnt;
    int hold;
    vcnt = 0;
    hold = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        bus.rsp_ready = (vcnt >= hold);
        vcnt++;
      end else begin
        vcnt = 0;
        hold = (hold_cfg >= 0) ? hold_cfg : int'($urandom_range(0, 3));
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t cur;
    logic hs;
    cur = '{default: 0};
    forever begin
      @(posedge clk);
      hs = bus.rsp_valid && bus.rsp_ready;
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_flags", {29'd0, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 32'd0);
        chk("rst_req_ready",  32'(bus.req_ready), 32'd0);
        chk("rst_alu_sel",    32'(alu_sel), 32'd0);
        mon_active = 1'b0;
      end else begin
        if (hs) begin
          chk("req_ready_after_rsp", 32'(bus.req_ready), 32'd1);
          chk("rsp_valid_drop",      32'(bus.rsp_valid), 32'd0);
          mon_active = 1'b0;
        end
        if (bus.rsp_valid) begin
          chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
          chk("alu_sel_resp",   32'(alu_sel), 32'd0);
          if (!mon_active) begin
            if (sbq.size() == 0) begin
              fail_note("unexpected_rsp");
            end else begin
              cur = sbq.pop_front();
              mon_active = 1'b1;
              chk("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat + 1));
              chk("result",  bus.rsp_result, cur.res);
              chk("carry",   32'(bus.rsp_carry), 32'(cur.carry));
              chk("zero",    32'(bus.rsp_zero), 32'(cur.zero));
              chk("err",     32'(bus.rsp_err), 32'(cur.err));
            end
          end else begin
            chk("hold_result", bus.rsp_result, cur.res);
            chk("hold_flags", {29'd0, bus.rsp_carry, bus.rsp_zero, bus.rsp_err},
                {29'd0, cur.carry, cur.zero, cur.err});
          end
        end
        if (bus.req_ready) begin
          chk("alu_idle_a",   alu_a, 32'd0);
          chk("alu_idle_b",   alu_b, 32'd0);
          chk("alu_idle_sel", 32'(alu_sel), 32'd0);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(3'd3, 32'd5, 32'd3);
    issue(3'd3, 32'd0, 32'd0);
    issue(3'd4, 32'd7, 32'd6);
    issue(3'd4, 32'h0001_0001, 32'h0001_0001);
    issue(3'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    issue(3'd6, 32'h1234_5678, 32'h9ABC_DEF0);
    drain();

    // Response held off for 3 valid cycles
    hold_cfg = 3;
    issue(3'd1, 32'h0000_00A5, 32'h0000_005A);
    issue(3'd3, 32'h0000_0010, 32'h0000_0020);
    drain();
    hold_cfg = -1;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a  = rnd_operand();
      b  = rnd_operand();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(op, a, b);
    end
    drain();

    // Reset in the middle of a multiply
    issue(3'd4, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    chk("abort_rsp_result", bus.rsp_result, 32'd0);
    chk("abort_flags", {29'd0, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 32'd0);
    chk("abort_req_ready",  32'(bus.req_ready), 32'd0);
    chk("abort_alu_a",      alu_a, 32'd0);
    chk("abort_alu_sel",    32'(alu_sel), 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(3'd2, 32'd2, 32'd2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
